// File: rtl/binary_sign_activation_packer.sv
// Binarises IN_SIZE signed results per beat and packs BEATS beats into an OUT_SIZE-bit vector. Output is valid 1 cycle after the final beat.
// Backpressure: only the final beat of a vector stalls on a full, undrained output register. Define BINARY_SIGN_ACTIVATION_THRESHOLD_EN to join a per-channel threshold stream.
module binary_sign_activation_packer #(
    parameter int IN_WIDTH = 8,
    parameter int IN_SIZE  = 2,
    parameter int OUT_SIZE = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]   data_in,
    input  logic                               data_in_valid,
    output logic                               data_in_ready,
    input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]   threshold,
    input  logic                               threshold_valid,
    output logic                               threshold_ready,
    output logic [OUT_SIZE-1:0]                data_out,
    output logic                               data_out_valid,
    input  logic                               data_out_ready
);

    localparam int BEATS = OUT_SIZE / IN_SIZE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]       cnt;
    logic [OUT_SIZE-1:0] fill;
    logic [OUT_SIZE-1:0] next_vec;
    logic [IN_SIZE-1:0]  bits;
    logic                last;
    logic                join_valid;
    logic                acc;

`ifdef BINARY_SIGN_ACTIVATION_THRESHOLD_EN
    assign join_valid      = data_in_valid && threshold_valid;
    assign threshold_ready = data_in_ready;

    always_comb begin
        bits = '0;
        for (int i = 0; i < IN_SIZE; i++)
            bits[i] = $signed(data_in[i]) >= $signed(threshold[i]);
    end
`else
    logic unused_threshold;

    assign unused_threshold = ^{threshold, threshold_valid};
    assign join_valid       = data_in_valid;
    assign threshold_ready  = 1'b1;

    // x >= 0 for a two's-complement value is just a clear sign bit
    always_comb begin
        bits = '0;
        for (int i = 0; i < IN_SIZE; i++)
            bits[i] = ~data_in[i][IN_WIDTH-1];
    end
`endif

    assign last          = (cnt == CW'(BEATS - 1));
    assign data_in_ready = !(last && data_out_valid && !data_out_ready);
    assign acc           = join_valid && data_in_ready;

    // Fill register with the current beat merged into its slot
    always_comb begin
        next_vec = fill;
        for (int j = 0; j < BEATS; j++)
            if (cnt == CW'(j))
                next_vec[j*IN_SIZE +: IN_SIZE] = bits;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            fill           <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            if (acc) begin
                fill <= next_vec;
                cnt  <= last ? '0 : cnt + CW'(1);
            end
            if (acc && last) begin
                data_out       <= next_vec;
                data_out_valid <= 1'b1;
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule
